// File: rtl/multdiv_iter_unit.sv
// Iterative signed multiply/divide unit for the execute-stage multdiv handshake.
// The multiplier is a shift/add design and the divider is a restoring divider;
// both share one iteration counter.
// Operands are captured when a start is sampled, so the initiator's operand
// buses are free while the unit is busy.
module multdiv_iter_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // State and datapath registers
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    // Per-iteration combinational terms
    logic             last_iter;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    prod_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] quot_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             prod_ovf;

    // Iteration datapath: one multiply step and one restoring divide step
    always_comb begin
        last_iter   = (cnt_q == CW'(WIDTH - 1));
        addend      = mplier_q[0] ? mcand_q : '0;
        // The multiplier MSB carries negative weight in two's complement
        prod_next   = last_iter ? (acc_q - addend) : (acc_q + addend);
        prod_ovf    = !((&prod_next[PW-1:WIDTH-1]) || !(|prod_next[PW-1:WIDTH-1]));
        rem_shift   = {rem_q, dvd_q[WIDTH-1]};
        trial       = rem_shift - {1'b0, dvs_q};
        rem_next    = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_next   = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
        quot_signed = neg_q ? (~quot_next + WIDTH'(1)) : quot_next;
        abs_a       = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
        abs_b       = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
    end

    // Next-state and next-output logic; a sampled start overrides everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            S_MUL: begin
                acc_d    = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d  = S_DONE;
                    result_d = prod_next[WIDTH-1:0];
                    exc_d    = prod_ovf;
                end
            end
            S_DIV: begin
                if (dz_q) begin
                    state_d  = S_DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    rem_d  = rem_next;
                    quot_d = quot_next;
                    dvd_d  = dvd_q << 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (last_iter) begin
                        state_d  = S_DONE;
                        result_d = quot_signed;
                        // Only MIN / -1 yields a positive magnitude of 2^(WIDTH-1)
                        exc_d    = !neg_q && quot_next[WIDTH-1];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ctrl_MULT) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
            mplier_d = data_operandB;
            acc_d    = '0;
            result_d = result_q;
            exc_d    = exc_q;
        end else if (ctrl_DIV) begin
            state_d  = S_DIV;
            cnt_d    = '0;
            dvd_d    = abs_a;
            dvs_d    = abs_b;
            rem_d    = '0;
            quot_d   = '0;
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d     = (data_operandB == '0);
            result_d = result_q;
            exc_d    = exc_q;
        end

        rdy_d  = (state_d == S_DONE);
        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    end

    // State register with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_iter_unit.sv
// Self-checking bench for multdiv_iter_unit: table vectors, random vectors
// against a 64-bit arithmetic model, and hand sequences for abort and reset.
module tb_multdiv_iter_unit;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           cyc;
    } exp_t;

    typedef struct {
        logic         do_mul;
        logic         do_div;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         exc;
        int           lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[13];
    vec_t rv;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    multdiv_iter_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model using native 64-bit signed arithmetic
    task automatic model(input logic is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic e);
        longint p;
        longint lim;
        lim = 64'sd2147483648;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p >= lim) || (p < -lim);
        end else if (b == '0) begin
            r = '0;
            e = 1'b1;
        end else begin
            p = longint'($signed(a)) / longint'($signed(b));
            r = p[31:0];
            e = (p >= lim) || (p < -lim);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expectation, including its cycle
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                check("strobe_unexpected", 64'(data_resultRDY), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("result", 64'(data_result), 64'(mon_e.res));
                check("exception", 64'(data_exception), 64'(mon_e.exc));
                check("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("busy_at_strobe", 64'(busy), 64'(0));
            end
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] res, input logic exc, input int lat, input logic expect_strobe);
        exp_t e;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (expect_strobe) begin
            e.res = res;
            e.exc = exc;
            e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        check("drain_timeout", 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        start_op(v.do_mul, v.do_div, v.a, v.b, v.res, v.exc, v.lat, 1'b1);
        wait_done();
        repeat (2) @(negedge clock);
        check("hold_result", 64'(data_result), 64'(v.res));
        check("hold_exception", 64'(data_exception), 64'(v.exc));
        check("strobe_one_cycle", 64'(data_resultRDY), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        //        mul   div   A             B             result        exc   lat
        tbl[0]  = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32};
        tbl[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 32};
        tbl[2]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1'b1, 32};
        tbl[3]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 1'b0, 32};
        tbl[4]  = '{1'b0, 1'b1, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 32};
        tbl[5]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 1'b0, 32};
        tbl[6]  = '{1'b0, 1'b1, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1};
        tbl[7]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32};
        tbl[8]  = '{1'b1, 1'b1, 32'h00000006, 32'h00000002, 32'h0000000C, 1'b0, 32};
        tbl[9]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 32};
        tbl[10] = '{1'b0, 1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, 32};
        tbl[11] = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 32};
        tbl[12] = '{1'b0, 1'b1, 32'h00000007, 32'h00000064, 32'h00000000, 1'b0, 32};

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_result", 64'(data_result), 64'(0));
        check("reset_exception", 64'(data_exception), 64'(0));
        check("reset_rdy", 64'(data_resultRDY), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

        // Random operands, half of them small so not every multiply overflows
        for (int i = 0; i < 12; i++) begin
            rv.do_mul = 1'($urandom_range(0, 1));
            rv.do_div = ~rv.do_mul;
            rv.a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 4000)) - 2000);
            rv.b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
            model(rv.do_mul, rv.a, rv.b, rv.res, rv.exc);
            rv.lat = (!rv.do_mul && rv.b == '0) ? 1 : 32;
            run_vec(rv);
        end

        // Abort: a divide started 10 cycles into a multiply replaces it
        start_op(1'b1, 1'b0, 32'd3, 32'd4, '0, 1'b0, 32, 1'b0);
        repeat (8) @(negedge clock);
        start_op(1'b0, 1'b1, 32'd20, 32'd5, 32'd4, 1'b0, 32, 1'b1);
        wait_done();
        repeat (40) @(negedge clock);

        // Asynchronous reset mid-multiply clears outputs without waiting for an edge
        run_vec('{1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0, 32});
        start_op(1'b1, 1'b0, 32'd11, 32'd13, '0, 1'b0, 32, 1'b0);
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_busy", 64'(busy), 64'(0));
        check("async_reset_rdy", 64'(data_resultRDY), 64'(0));
        check("async_reset_result", 64'(data_result), 64'(0));
        check("async_reset_exception", 64'(data_exception), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        run_vec('{1'b1, 1'b0, 32'd9, 32'd9, 32'd81, 1'b0, 32});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
